// File: rtl/axi_ram_rd_checker.sv
// AXI4 read-only sweep master: reads a word range in INCR bursts (one outstanding, no 4 KB crossing)
// and checks each beat against the RAM power-on pattern, word i == i*8.
module axi_ram_rd_checker #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 16,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int ID_WIDTH      = 8,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [15:0]           num_beats,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int LSB        = $clog2(STRB_WIDTH);
  localparam int BOUND_BITS = (ADDR_WIDTH < 12) ? ADDR_WIDTH : 12;
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK  = ADDR_WIDTH'((1 << LSB) - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(STRB_WIDTH);
  localparam logic [16:0]           MAX_LEN   = 17'(MAX_BURST_LEN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // Beats in the next burst: limited by words remaining, the burst cap and the next 4 KB (or wrap) boundary.
  function automatic logic [8:0] burst_beats(input logic [ADDR_WIDTH-1:0] a, input logic [15:0] rem);
    logic [16:0] to_bound;
    logic [16:0] beats;
    to_bound = ((17'd1 << BOUND_BITS) - 17'(a[BOUND_BITS-1:0])) >> LSB;
    beats    = {1'b0, rem};
    beats    = (MAX_LEN < beats) ? MAX_LEN : beats;
    beats    = (to_bound < beats) ? to_bound : beats;
    return beats[8:0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] word;
    word = a >> LSB;
    return DATA_WIDTH'(word) << 3;
  endfunction

  state_t                state_r, state_s;
  logic [ADDR_WIDTH-1:0] addr_r, addr_s;
  logic [15:0]           remaining_r, remaining_s;
  logic [8:0]            beats_left_r, beats_left_s;
  logic                  err_seen_r, err_seen_s;
  logic                  busy_r, busy_s;
  logic                  done_r, done_s;
  logic [15:0]           err_count_r, err_count_s;
  logic [ADDR_WIDTH-1:0] first_err_addr_r, first_err_addr_s;
  logic                  arvalid_r, arvalid_s;
  logic [ADDR_WIDTH-1:0] araddr_r, araddr_s;
  logic [7:0]            arlen_r, arlen_s;
  logic                  rready_r, rready_s;

  logic [ADDR_WIDTH-1:0] start_addr_s;
  logic [ADDR_WIDTH-1:0] next_addr_s;
  logic [15:0]           next_rem_s;
  logic [8:0]            beats_s;
  logic                  last_beat_s;
  logic                  beat_err_s;

  // Next-state and next-output computation for the sweep FSM.
  always_comb begin
    state_s          = state_r;
    addr_s           = addr_r;
    remaining_s      = remaining_r;
    beats_left_s     = beats_left_r;
    err_seen_s       = err_seen_r;
    busy_s           = busy_r;
    done_s           = 1'b0;
    err_count_s      = err_count_r;
    first_err_addr_s = first_err_addr_r;
    arvalid_s        = arvalid_r;
    araddr_s         = araddr_r;
    arlen_s          = arlen_r;
    rready_s         = rready_r;
    start_addr_s     = base_addr & ~LOW_MASK;
    next_addr_s      = addr_r + ADDR_STEP;
    next_rem_s       = remaining_r - 16'd1;
    beats_s          = 9'd0;
    last_beat_s      = (beats_left_r == 9'd1);
    beat_err_s       = (m_axi_rdata != pattern(addr_r)) || (m_axi_rresp != 2'b00) ||
                       (m_axi_rlast != last_beat_s);

    case (state_r)
      ST_IDLE: begin
        if (start && (num_beats != 16'd0)) begin
          beats_s          = burst_beats(start_addr_s, num_beats);
          addr_s           = start_addr_s;
          remaining_s      = num_beats;
          beats_left_s     = beats_s;
          err_seen_s       = 1'b0;
          err_count_s      = 16'd0;
          first_err_addr_s = '0;
          busy_s           = 1'b1;
          arvalid_s        = 1'b1;
          araddr_s         = start_addr_s;
          arlen_s          = 8'(beats_s - 9'd1);
          state_s          = ST_ADDR;
        end else if (start) begin
          done_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (m_axi_arready) begin
          arvalid_s = 1'b0;
          rready_s  = 1'b1;
          state_s   = ST_DATA;
        end else begin
          state_s = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (m_axi_rvalid) begin
          if (beat_err_s) begin
            err_count_s = (err_count_r != 16'hFFFF) ? (err_count_r + 16'd1) : err_count_r;
            if (!err_seen_r) begin
              err_seen_s       = 1'b1;
              first_err_addr_s = addr_r;
            end else begin
              err_seen_s = 1'b1;
            end
          end else begin
            err_count_s = err_count_r;
          end
          addr_s       = next_addr_s;
          remaining_s  = next_rem_s;
          beats_left_s = beats_left_r - 9'd1;
          if (last_beat_s) begin
            rready_s = 1'b0;
            if (next_rem_s != 16'd0) begin
              beats_s      = burst_beats(next_addr_s, next_rem_s);
              beats_left_s = beats_s;
              arvalid_s    = 1'b1;
              araddr_s     = next_addr_s;
              arlen_s      = 8'(beats_s - 9'd1);
              state_s      = ST_ADDR;
            end else begin
              busy_s  = 1'b0;
              done_s  = 1'b1;
              state_s = ST_IDLE;
            end
          end else begin
            rready_s = 1'b1;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        busy_s    = 1'b0;
        arvalid_s = 1'b0;
        rready_s  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= ST_IDLE;
      addr_r           <= '0;
      remaining_r      <= 16'd0;
      beats_left_r     <= 9'd0;
      err_seen_r       <= 1'b0;
      busy_r           <= 1'b0;
      done_r           <= 1'b0;
      err_count_r      <= 16'd0;
      first_err_addr_r <= '0;
      arvalid_r        <= 1'b0;
      araddr_r         <= '0;
      arlen_r          <= 8'd0;
      rready_r         <= 1'b0;
    end else begin
      state_r          <= state_s;
      addr_r           <= addr_s;
      remaining_r      <= remaining_s;
      beats_left_r     <= beats_left_s;
      err_seen_r       <= err_seen_s;
      busy_r           <= busy_s;
      done_r           <= done_s;
      err_count_r      <= err_count_s;
      first_err_addr_r <= first_err_addr_s;
      arvalid_r        <= arvalid_s;
      araddr_r         <= araddr_s;
      arlen_r          <= arlen_s;
      rready_r         <= rready_s;
    end
  end

  assign busy           = busy_r;
  assign done           = done_r;
  assign err_count      = err_count_r;
  assign first_err_addr = first_err_addr_r;
  assign m_axi_arid     = '0;
  assign m_axi_araddr   = araddr_r;
  assign m_axi_arlen    = arlen_r;
  assign m_axi_arsize   = 3'(LSB);
  assign m_axi_arburst  = 2'b01;
  assign m_axi_arvalid  = arvalid_r;
  assign m_axi_rready   = rready_r;

endmodule
